ixc_bind_arb: RTL and testbench
===============================

Name: ixc_bind_arb

Overview:
- Parametrised successor to the fixed 4-bit IXCOM bind primitive. It resolves a shared multi-driver net for emulation, where real tristate resolution is unavailable.
- Up to CHANNELS drivers request the net. A registered round-robin arbiter grants ownership to one driver, with optional fairness timeout.
- Produces a registered resolved value with keeper or pull semantics, and counts contention events.
- Sits in IXCOM temp library in place of bind instances on inout buses.

Parameters:
- WIDTH, 4, bit width of shared net
- CHANNELS, 2, number of drivers (2..16)
- MAX_OWN, 0, max consecutive owned cycles while others wait before forced rotation; 0 disables
- KEEPER, 1, 1 = net holds last value when unowned; 0 = net takes PULL_VAL
- PULL_VAL, 0, WIDTH-bit value when unowned and KEEPER=0; also reset value of bus_out
- CNT_W, 8, contention counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  CHANNELS  per-driver drive request (level)
- drv_data  in  CHANNELS*WIDTH  driver data, channel i at [i*WIDTH +: WIDTH]
- clr_err  in  1  clears contention flag and counter
- grant  out  CHANNELS  registered one-hot ownership (all-zero = unowned)
- owner_id  out  $clog2(CHANNELS)  index of current owner (valid when bus_valid=1)
- bus_out  out  WIDTH  resolved net value
- bus_valid  out  1  registered; 1 when bus_out reflects an owner's data
- contention  out  1  sticky: ≥2 simultaneous requests seen
- contention_cnt  out  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (async, immediate):
  - grant=0, owner_id=0, bus_out=PULL_VAL, bus_valid=0, contention=0, contention_cnt=0.
  - Internal last-owner pointer = CHANNELS-1, so channel 0 wins first. Ownership age counter = 0.
  - Reset mid-ownership drops the grant immediately. No state survives.
- States: IDLE (grant=0), OWNED (grant one-hot).
- IDLE:
  - If any req, select the first requesting channel searching upward from (last_owner+1) mod CHANNELS with wrap.
  - Next cycle: OWNED, grant set, last_owner updated, age=1.
  - If no req: stay IDLE.
- OWNED, evaluated each cycle on sampled req:
  - Owner req=0: release. If another channel requests, grant it this edge via round-robin from owner+1 (OWNED→OWNED, no idle bubble). Else go to IDLE.
  - Owner req=1, MAX_OWN>0, age≥MAX_OWN, another channel requesting: forced rotation to next requester via round-robin.
  - Otherwise hold ownership. age increments, saturating at MAX_OWN.
  - Any ownership change resets age to 1.
  - Owner release and timeout in the same cycle is treated as a normal release.
- Data path, 1-cycle latency from grant:
  - When grant(t) ≠ 0: bus_out(t+1) = drv_data[owner(t)] and bus_valid(t+1) = 1.
  - When grant(t) = 0: bus_valid(t+1) = 0. bus_out holds its value if KEEPER=1, else becomes PULL_VAL.
- Contention:
  - A cycle with popcount(req) ≥ 2 sets contention and increments contention_cnt, saturating at 2^CNT_W-1 with no wrap.
  - clr_err zeroes flag and counter. If contention occurs in the same cycle as clr_err: flag=1, counter=1.
- grant is always one-hot or zero. A grant is never given to a channel whose req was 0 at the deciding edge.

Test Plan:
- Reset, then req=2'b01, drv_data ch0=4'hA → grant=01 after 1 edge; bus_out=A, bus_valid=1 one edge later.
- CHANNELS=4: req=4'b1111 held, MAX_OWN=3 → owners rotate 0,1,2,3,0, each held exactly 3 cycles. contention_cnt increments every cycle.
- Owner ch1 drops req while ch3 requests → grant moves 0010→1000 on the same edge with no IDLE cycle. bus_out shows ch3 data next cycle.
- All req drop with bus_out=4'h5: KEEPER=1 → bus_out stays 5, bus_valid=0. KEEPER=0, PULL_VAL=4'hF → bus_out=F.
- CNT_W=2 with 5 contention cycles → counter saturates at 3. clr_err together with contention → counter=1, flag=1.
- Assert rst mid-ownership between edges → grant, bus_valid, bus_out clear immediately (no clock). After release, ch0 is granted first.

Source files
------------

// File: rtl/ixc_bind_arb.sv
// ixc_bind_arb
// -----------------------------------------------------------------------------
// Resolves a shared multi-driver net for emulation targets that have no real
// tristate resolution. Up to CHANNELS drivers request the net. A registered
// round-robin arbiter hands ownership to one of them, and an optional fairness
// timeout rotates ownership away from a driver that holds the net too long.
// The resolved value is registered one cycle behind the grant. When no driver
// owns the net, it either keeps its last value or falls back to a pull value.
// Cycles with two or more simultaneous requests are flagged and counted.
//
// Parameters:
//   WIDTH     bit width of the shared net
//   CHANNELS  number of drivers (2..16)
//   MAX_OWN   consecutive owned cycles while others wait before a forced
//             rotation; 0 disables the timeout
//   KEEPER    1 = net holds its last value when unowned, 0 = net takes PULL_VAL
//   PULL_VAL  unowned value when KEEPER=0; also the reset value of bus_out
//   CNT_W     width of the saturating contention counter
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   req             per-driver level request
//   drv_data        driver data, channel i at [i*WIDTH +: WIDTH]
//   clr_err         clears the contention flag and counter
//   grant           registered one-hot ownership (all zero = unowned)
//   owner_id        channel whose data is on bus_out (valid when bus_valid=1)
//   bus_out         resolved net value
//   bus_valid       1 when bus_out carries an owner's data
//   contention      sticky flag, set by any cycle with two or more requests
//   contention_cnt  saturating count of contention cycles
module ixc_bind_arb #(
    parameter int                WIDTH    = 4,
    parameter int                CHANNELS = 2,
    parameter int                MAX_OWN  = 0,
    parameter bit                KEEPER   = 1'b1,
    parameter logic [WIDTH-1:0]  PULL_VAL = '0,
    parameter int                CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           req,
    input  logic [CHANNELS*WIDTH-1:0]     drv_data,
    input  logic                          clr_err,
    output logic [CHANNELS-1:0]           grant,
    output logic [$clog2(CHANNELS)-1:0]   owner_id,
    output logic [WIDTH-1:0]              bus_out,
    output logic                          bus_valid,
    output logic                          contention,
    output logic [CNT_W-1:0]              contention_cnt
);

    localparam int ID_W  = $clog2(CHANNELS);
    localparam int AGE_W = (MAX_OWN < 1) ? 1 : $clog2(MAX_OWN + 1);
    localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_OWN);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CHANNELS-1:0]  grant_nxt;
    logic [ID_W-1:0]      last_owner;
    logic [ID_W-1:0]      last_owner_nxt;
    logic [AGE_W-1:0]     age;
    logic [AGE_W-1:0]     age_nxt;

    logic [CHANNELS-1:0]  others;
    logic                 owner_req;
    logic [ID_W-1:0]      pick;
    logic                 timed_out;
    logic                 multi_req;

    logic [WIDTH-1:0]     chan_data [CHANNELS];

    // Searches upward from the channel after 'last', wrapping around. The
    // channel 'last' itself is tried only at the very end of the search.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [CHANNELS-1:0] cand,
        input logic [ID_W-1:0]     last
    );
        logic [ID_W-1:0] sel;
        logic [ID_W-1:0] cidx;
        logic            found;
        int              c;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            c = int'(last) + i;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            cidx = c[ID_W-1:0];
            if (!found && cand[cidx]) begin
                found = 1'b1;
                sel   = cidx;
            end
        end
        return sel;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign chan_data[g] = drv_data[g*WIDTH +: WIDTH];
    end

    // While idle the grant is zero, so 'others' is simply every requester.
    // While owned, last_owner is the current owner, so searching from it
    // gives the round-robin successor among the remaining requesters.
    assign others    = req & ~grant;
    assign owner_req = |(req & grant);
    assign pick      = rr_pick(others, last_owner);
    assign timed_out = (MAX_OWN > 0) && (age >= MAX_AGE);

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_req = |(req & (req - CHANNELS'(1)));

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= ID_W'(CHANNELS - 1);
            age        <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_owner <= last_owner_nxt;
            age        <= age_nxt;
        end
    end

    // Ownership decisions. Release takes priority over the timeout, and a
    // release with another requester hands over directly with no idle cycle.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_owner_nxt = last_owner;
        age_nxt        = age;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt       = OWNED;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    last_owner_nxt  = pick;
                    age_nxt         = AGE_W'(1);
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    if (|others) begin
                        grant_nxt       = '0;
                        grant_nxt[pick] = 1'b1;
                        last_owner_nxt  = pick;
                        age_nxt         = AGE_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (timed_out && (|others)) begin
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    last_owner_nxt  = pick;
                    age_nxt         = AGE_W'(1);
                end else if (age < MAX_AGE) begin
                    age_nxt = age + AGE_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Resolved net, one cycle behind the grant. owner_id follows the data so
    // it always names the driver whose value is currently on bus_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_out   <= PULL_VAL;
            bus_valid <= 1'b0;
            owner_id  <= '0;
        end else if (|grant) begin
            bus_out   <= chan_data[last_owner];
            bus_valid <= 1'b1;
            owner_id  <= last_owner;
        end else begin
            bus_valid <= 1'b0;
            if (!KEEPER) begin
                bus_out <= PULL_VAL;
            end
        end
    end

    // Contention tracking. A clear in the same cycle as new contention
    // leaves that cycle counted, so the flag ends at 1 and the counter at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
        end else if (clr_err) begin
            contention     <= multi_req;
            contention_cnt <= multi_req ? CNT_W'(1) : '0;
        end else if (multi_req) begin
            contention <= 1'b1;
            if (contention_cnt != '1) begin
                contention_cnt <= contention_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ixc_bind_arb.sv
// tb_ixc_bind_arb
// -----------------------------------------------------------------------------
// Directed bench for ixc_bind_arb using two instances sharing clock and reset:
//   dut_a: CHANNELS=4, MAX_OWN=3, KEEPER=1, CNT_W=2 (rotation, hand-over,
//          keeper, counter saturation and clear, async reset)
//   dut_b: CHANNELS=2, MAX_OWN=0, KEEPER=0, PULL_VAL=F (basic grant latency,
//          pull value, no forced rotation)
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point after the following edge.
module tb_ixc_bind_arb;

    logic        clk;
    logic        rst;

    logic [3:0]  req_a;
    logic [15:0] drv_a;
    logic        clr_a;
    logic [3:0]  grant_a;
    logic [1:0]  id_a;
    logic [3:0]  bus_a;
    logic        valid_a;
    logic        cont_a;
    logic [1:0]  cnt_a;

    logic [1:0]  req_b;
    logic [7:0]  drv_b;
    logic        clr_b;
    logic [1:0]  grant_b;
    logic [0:0]  id_b;
    logic [3:0]  bus_b;
    logic        valid_b;
    logic        cont_b;
    logic [7:0]  cnt_b;

    int          checks;
    int          passes;
    int          exp_own;

    ixc_bind_arb #(
        .WIDTH(4), .CHANNELS(4), .MAX_OWN(3), .KEEPER(1'b1),
        .PULL_VAL(4'h0), .CNT_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .drv_data(drv_a), .clr_err(clr_a),
        .grant(grant_a), .owner_id(id_a), .bus_out(bus_a), .bus_valid(valid_a),
        .contention(cont_a), .contention_cnt(cnt_a)
    );

    ixc_bind_arb #(
        .WIDTH(4), .CHANNELS(2), .MAX_OWN(0), .KEEPER(1'b0),
        .PULL_VAL(4'hF), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .drv_data(drv_b), .clr_err(clr_b),
        .grant(grant_b), .owner_id(id_b), .bus_out(bus_b), .bus_valid(valid_b),
        .contention(cont_b), .contention_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic applyStimulus(input logic [3:0] ra, input logic ca,
                                 input logic [1:0] rb);
        req_a = ra;
        clr_a = ca;
        req_b = rb;
        clr_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        req_a  = '0;
        clr_a  = 1'b0;
        drv_a  = {4'h4, 4'h3, 4'h2, 4'h1};
        req_b  = '0;
        clr_b  = 1'b0;
        drv_b  = {4'h5, 4'hA};

        #2;
        checkOutput("rst_grant_a", grant_a, 4'b0000);
        checkOutput("rst_bus_a", bus_a, 4'h0);
        checkOutput("rst_valid_a", valid_a, 1'b0);
        checkOutput("rst_id_a", id_a, 2'd0);
        checkOutput("rst_cont_a", cont_a, 1'b0);
        checkOutput("rst_cnt_a", cnt_a, 2'd0);
        checkOutput("rst_bus_b", bus_b, 4'hF);
        checkOutput("rst_grant_b", grant_b, 2'b00);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four request continuously: each owns for exactly 3 cycles.
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(4'b1111, 1'b0, 2'b00);
            exp_own = ((k - 1) / 3) % 4;
            checkOutput($sformatf("rot_grant_%0d", k), grant_a, 32'(1) << exp_own);
            checkOutput($sformatf("rot_cnt_%0d", k), cnt_a, (k < 3) ? k : 3);
            if (k >= 2) begin
                checkOutput($sformatf("rot_bus_%0d", k), bus_a, ((k - 2) / 3) % 4 + 1);
            end
        end
        checkOutput("rot_flag", cont_a, 1'b1);

        // Clear coinciding with contention, then a clear without it.
        applyStimulus(4'b1111, 1'b1, 2'b00);
        checkOutput("clr_cont_cnt", cnt_a, 2'd1);
        checkOutput("clr_cont_flag", cont_a, 1'b1);
        checkOutput("clr_cont_grant", grant_a, 4'b0001);
        applyStimulus(4'b0001, 1'b1, 2'b00);
        checkOutput("clr_cnt", cnt_a, 2'd0);
        checkOutput("clr_flag", cont_a, 1'b0);

        // ch0 releases to ch1, then ch1 releases straight to ch3.
        applyStimulus(4'b0010, 1'b0, 2'b00);
        checkOutput("rel0_grant", grant_a, 4'b0010);
        applyStimulus(4'b1010, 1'b0, 2'b00);
        checkOutput("hold1_grant", grant_a, 4'b0010);
        checkOutput("hold1_cnt", cnt_a, 2'd1);
        applyStimulus(4'b1000, 1'b0, 2'b00);
        checkOutput("hand_grant", grant_a, 4'b1000);
        checkOutput("hand_bus", bus_a, 4'h2);
        checkOutput("hand_valid", valid_a, 1'b1);
        applyStimulus(4'b1000, 1'b0, 2'b00);
        checkOutput("hand_bus3", bus_a, 4'h4);
        checkOutput("hand_id3", id_a, 2'd3);

        // Keeper: net holds 5 after everyone lets go.
        drv_a[15:12] = 4'h5;
        applyStimulus(4'b1000, 1'b0, 2'b00);
        checkOutput("keep_bus5", bus_a, 4'h5);
        applyStimulus(4'b0000, 1'b0, 2'b00);
        checkOutput("keep_grant0", grant_a, 4'b0000);
        checkOutput("keep_valid_last", valid_a, 1'b1);
        applyStimulus(4'b0000, 1'b0, 2'b00);
        checkOutput("keep_bus", bus_a, 4'h5);
        checkOutput("keep_valid", valid_a, 1'b0);

        // Idle arbitration from last owner ch3 finds ch2.
        applyStimulus(4'b0100, 1'b0, 2'b00);
        checkOutput("idle_grant2", grant_a, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 2'b00);
        checkOutput("idle_bus2", bus_a, 4'h3);
        checkOutput("idle_id2", id_a, 2'd2);

        // Asynchronous reset between edges clears outputs at once.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_grant", grant_a, 4'b0000);
        checkOutput("arst_valid", valid_a, 1'b0);
        checkOutput("arst_bus", bus_a, 4'h0);
        checkOutput("arst_cnt", cnt_a, 2'd0);
        checkOutput("arst_bus_b", bus_b, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b0, 2'b00);
        checkOutput("arst_first_ch0", grant_a, 4'b0001);

        // dut_b: grant after one edge, data one edge later, then pull value.
        applyStimulus(4'b0000, 1'b0, 2'b01);
        checkOutput("b_grant", grant_b, 2'b01);
        checkOutput("b_valid0", valid_b, 1'b0);
        checkOutput("b_bus_pull", bus_b, 4'hF);
        applyStimulus(4'b0000, 1'b0, 2'b01);
        checkOutput("b_bus_a", bus_b, 4'hA);
        checkOutput("b_valid1", valid_b, 1'b1);
        checkOutput("b_id0", id_b, 1'b0);
        applyStimulus(4'b0000, 1'b0, 2'b00);
        checkOutput("b_grant_rel", grant_b, 2'b00);
        checkOutput("b_bus_last", bus_b, 4'hA);
        applyStimulus(4'b0000, 1'b0, 2'b00);
        checkOutput("b_bus_pullF", bus_b, 4'hF);
        checkOutput("b_valid_off", valid_b, 1'b0);

        // dut_b: no timeout, so ch1 keeps the net under contention.
        applyStimulus(4'b0000, 1'b0, 2'b11);
        checkOutput("b_rr_grant", grant_b, 2'b10);
        checkOutput("b_cnt1", cnt_b, 8'd1);
        applyStimulus(4'b0000, 1'b0, 2'b11);
        checkOutput("b_hold_grant", grant_b, 2'b10);
        checkOutput("b_bus5", bus_b, 4'h5);
        checkOutput("b_id1", id_b, 1'b1);
        applyStimulus(4'b0000, 1'b0, 2'b11);
        checkOutput("b_hold_grant2", grant_b, 2'b10);
        checkOutput("b_cnt3", cnt_b, 8'd3);
        checkOutput("b_flag", cont_b, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
